// File: rtl/synth_ctrl_pkg.sv
// Shared definitions for the synth control bus: register map, master FSM states, event record.
package synth_ctrl_pkg;

    localparam int unsigned ADSR_BASE_ADDR  = 16;
    localparam int unsigned KEY_BASE_ADDR   = 32;
    localparam int unsigned FREQ_BASE_ADDR  = 40;
    localparam int unsigned AMP_BASE_ADDR   = 48;
    localparam int unsigned SHAPE_BASE_ADDR = 56;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ALLOC   = 3'd1;
    localparam state_t ST_KOFF    = 3'd2;
    localparam state_t ST_FREQ    = 3'd3;
    localparam state_t ST_AMP     = 3'd4;
    localparam state_t ST_KON     = 3'd5;
    localparam state_t ST_ALLOFF  = 3'd6;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [6:0] vel;
    } evt_t;

    function automatic logic [5:0] word_addr(input int unsigned base, input int unsigned idx);
        word_addr = 6'(base + idx);
    endfunction

endpackage

// File: rtl/voice_alloc.sv
// Voice table (gate + note per voice, round-robin steal pointer) with the priority searches
// used to pick a voice for an incoming event and to walk held voices during all-off.
module voice_alloc
    import synth_ctrl_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  query_on,
    input  logic [6:0]            query_note,
    output logic [VW-1:0]         voice,
    output logic                  steal,
    output logic                  match,
    output logic                  none,
    input  logic                  steal_adv,
    input  logic                  kon_done,
    input  logic                  koff_done,
    input  logic [VW-1:0]         done_voice,
    input  logic [6:0]            done_note,
    output logic [NUM_VOICES-1:0] held,
    output logic [VW-1:0]         low_held,
    output logic                  any_held
);

    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

    logic [NUM_VOICES-1:0] held_q;
    logic [6:0]            note_q [NUM_VOICES];
    logic [VW-1:0]         steal_ptr_q;

    logic [VW-1:0] match_idx;
    logic [VW-1:0] free_idx;
    logic          match_hit;
    logic          free_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q      <= '0;
            steal_ptr_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
            end
        end else begin
            if (steal_adv) begin
                steal_ptr_q <= (steal_ptr_q == LAST_VOICE) ? '0 : steal_ptr_q + 1'b1;
            end
            if (koff_done) begin
                held_q[done_voice] <= 1'b0;
            end
            if (kon_done) begin
                held_q[done_voice] <= 1'b1;
                note_q[done_voice] <= done_note;
            end
        end
    end

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        match_idx = '0;
        match_hit = 1'b0;
        free_idx  = '0;
        free_hit  = 1'b0;
        low_held  = '0;
        any_held  = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (held_q[i] && note_q[i] == query_note) begin
                match_hit = 1'b1;
                match_idx = VW'(i);
            end
            if (!held_q[i]) begin
                free_hit = 1'b1;
                free_idx = VW'(i);
            end
            if (held_q[i]) begin
                any_held = 1'b1;
                low_held = VW'(i);
            end
        end
    end

    always_comb begin
        voice = '0;
        steal = 1'b0;
        match = 1'b0;
        none  = 1'b0;
        if (match_hit) begin
            voice = match_idx;
            match = 1'b1;
        end else if (!query_on) begin
            none = 1'b1;
        end else if (free_hit) begin
            voice = free_idx;
        end else begin
            voice = steal_ptr_q;
            steal = 1'b1;
        end
    end

    assign held = held_q;

endmodule

// File: rtl/note_event_avm_master.sv
// Avalon-MM write master turning note-on/off events into KEY/FREQ/AMP register writes,
// one voice per held note, with round-robin stealing and a latched all-notes-off.
module note_event_avm_master
    import synth_ctrl_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_BASE   = KEY_BASE_ADDR,
    parameter int unsigned FREQ_BASE  = FREQ_BASE_ADDR,
    parameter int unsigned AMP_BASE   = AMP_BASE_ADDR
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EVT_VALID,
    output logic                  EVT_READY,
    input  logic                  EVT_ON,
    input  logic [6:0]            EVT_NOTE,
    input  logic [6:0]            EVT_VEL,
    input  logic                  ALL_OFF,
    output logic [5:0]            AVM_ADDR,
    output logic                  AVM_WRITE,
    output logic                  AVM_CS,
    output logic [3:0]            AVM_BYTE_EN,
    output logic [31:0]           AVM_WRITEDATA,
    input  logic                  AVM_WAITREQUEST,
    output logic [NUM_VOICES-1:0] VOICE_HELD
);

    localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t        state_q, state_d;
    evt_t          evt_q, evt_d;
    logic [VW-1:0] voice_q, voice_d;
    logic          alloff_q, alloff_d;

    logic [VW-1:0] alloc_voice;
    logic          alloc_steal;
    logic          alloc_match;
    logic          alloc_none;
    logic          steal_adv;
    logic          kon_done;
    logic          koff_done;
    logic [VW-1:0] done_voice;
    logic [VW-1:0] low_held;
    logic          any_held;
    logic          wr_done;

    voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .VW         (VW)
    ) u_voice_alloc (
        .clk        (CLK),
        .reset      (RESET),
        .query_on   (evt_q.on),
        .query_note (evt_q.note),
        .voice      (alloc_voice),
        .steal      (alloc_steal),
        .match      (alloc_match),
        .none       (alloc_none),
        .steal_adv  (steal_adv),
        .kon_done   (kon_done),
        .koff_done  (koff_done),
        .done_voice (done_voice),
        .done_note  (evt_q.note),
        .held       (VOICE_HELD),
        .low_held   (low_held),
        .any_held   (any_held)
    );

    assign wr_done    = AVM_WRITE & ~AVM_WAITREQUEST;
    assign done_voice = (state_q == ST_ALLOFF) ? low_held : voice_q;
    assign EVT_READY  = (state_q == ST_IDLE) & ~alloff_q & ~RESET;

    always_comb begin
        state_d   = state_q;
        evt_d     = evt_q;
        voice_d   = voice_q;
        alloff_d  = alloff_q | ALL_OFF;
        steal_adv = 1'b0;
        kon_done  = 1'b0;
        koff_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending all-off pre-empts any event offered this cycle.
                if (alloff_q) begin
                    alloff_d = ALL_OFF;
                    state_d  = ST_ALLOFF;
                end else if (EVT_VALID) begin
                    evt_d   = '{on: EVT_ON, note: EVT_NOTE, vel: EVT_VEL};
                    state_d = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                voice_d = alloc_voice;
                if (alloc_none) begin
                    state_d = ST_IDLE;
                end else if (alloc_steal || (!evt_q.on && alloc_match)) begin
                    steal_adv = alloc_steal;
                    state_d   = ST_KOFF;
                end else begin
                    state_d = ST_FREQ;
                end
            end
            ST_KOFF: begin
                if (wr_done) begin
                    koff_done = 1'b1;
                    state_d   = evt_q.on ? ST_FREQ : ST_IDLE;
                end
            end
            ST_FREQ: if (wr_done) state_d = ST_AMP;
            ST_AMP:  if (wr_done) state_d = ST_KON;
            ST_KON: begin
                if (wr_done) begin
                    kon_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_ALLOFF: begin
                if (!any_held) begin
                    state_d = ST_IDLE;
                end else if (wr_done) begin
                    koff_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        AVM_WRITE     = 1'b0;
        AVM_ADDR      = '0;
        AVM_WRITEDATA = '0;
        case (state_q)
            ST_KOFF: begin
                AVM_WRITE = 1'b1;
                AVM_ADDR  = word_addr(KEY_BASE, 32'(voice_q));
            end
            ST_FREQ: begin
                AVM_WRITE     = 1'b1;
                AVM_ADDR      = word_addr(FREQ_BASE, 32'(voice_q));
                AVM_WRITEDATA = {25'b0, evt_q.note};
            end
            ST_AMP: begin
                AVM_WRITE     = 1'b1;
                AVM_ADDR      = word_addr(AMP_BASE, 32'(voice_q));
                AVM_WRITEDATA = {16'b0, evt_q.vel, 9'b0};
            end
            ST_KON: begin
                AVM_WRITE     = 1'b1;
                AVM_ADDR      = word_addr(KEY_BASE, 32'(voice_q));
                AVM_WRITEDATA = 32'd1;
            end
            ST_ALLOFF: begin
                if (any_held) begin
                    AVM_WRITE = 1'b1;
                    AVM_ADDR  = word_addr(KEY_BASE, 32'(low_held));
                end
            end
            default: ;
        endcase
    end

    assign AVM_CS      = AVM_WRITE;
    assign AVM_BYTE_EN = 4'hF;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            evt_q    <= '0;
            voice_q  <= '0;
            alloff_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            evt_q    <= evt_d;
            voice_q  <= voice_d;
            alloff_q <= alloff_d;
        end
    end

endmodule
